// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch/issue front end.
//   fetch_state_t : fetch controller states
//   NOP_INSTR     : bubble encoding handed to decode on empty cycles
//   OPC_J/OPC_JAL : opcodes recognised by the optional predecoder
//   is_jump()     : predecode helper, true for J / JAL encodings
//   sext11()      : sign-extends an 11-bit jump offset to 16 bits
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OPC_J     = 5'b00100;
    localparam logic [4:0]  OPC_JAL   = 5'b00110;

    function automatic logic is_jump(input logic [15:0] instr);
        return (instr[15:11] == OPC_J) || (instr[15:11] == OPC_JAL);
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] imm);
        return {{5{imm[10]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC select for the fetch unit.
// Priority: reset > redirect > capture (predecode target or pc+2) > hold pc.
// Optional macro FETCH_PREDECODE_EN: when defined, a captured J/JAL steers the
// PC straight to pc+2+sext(offset) and flags the instruction as predicted.
// Ports:
//   i_rst         synchronous reset request
//   i_redirect    control transfer resolved downstream
//   i_redirect_pc redirect target
//   i_capture     an instruction is being accepted this cycle
//   i_instr       instruction word being accepted
//   i_pc          current PC
//   o_next_pc     PC value for the next cycle
//   o_pc_plus2    current PC + 2 (wraps at 16 bits)
//   o_predicted   captured instruction already steered the PC
// -----------------------------------------------------------------------------
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_capture,
    input  logic [15:0] i_instr,
    input  logic [15:0] i_pc,
    output logic [15:0] o_next_pc,
    output logic [15:0] o_pc_plus2,
    output logic        o_predicted
);

    assign o_pc_plus2 = i_pc + 16'd2;

`ifndef FETCH_PREDECODE_EN
    // Instruction bits only matter to the predecoder.
    logic w_unused_instr;
    assign w_unused_instr = ^i_instr;
`endif

    // Next-PC priority mux.
    always_comb begin
        o_next_pc   = i_pc;
        o_predicted = 1'b0;
        if (i_rst) begin
            o_next_pc = RESET_PC;
        end else if (i_redirect) begin
            o_next_pc = i_redirect_pc;
        end else if (i_capture) begin
`ifdef FETCH_PREDECODE_EN
            if (is_jump(i_instr)) begin
                o_next_pc   = o_pc_plus2 + sext11(i_instr[10:0]);
                o_predicted = 1'b1;
            end else begin
                o_next_pc   = o_pc_plus2;
                o_predicted = 1'b0;
            end
`else
            o_next_pc = o_pc_plus2;
`endif
        end else begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/fetch_issue.sv
// -----------------------------------------------------------------------------
// fetch_issue
// Front end of the 5-stage pipeline: owns the PC, issues instruction-memory
// reads and presents instruction_fd / pc_plus2_fd to decode. All outputs are
// registered. Empty cycles carry NOP_INSTR with valid_fd=0.
// Optional macro FETCH_PREDECODE_EN enables J/JAL predecode steering
// (predicted_fd); otherwise fetch is strictly sequential and predicted_fd=0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hold_d          decode cannot accept (freeze presented instruction)
//   redirect        flush fetch and restart at redirect_pc
//   halt_d          decode holds HALT; stop fetching until reset
//   imem_rd/addr    read request to instruction memory
//   imem_data/done  returned instruction and its valid strobe
//   imem_stall      memory busy (request stays asserted)
//   instruction_fd  instruction to decode
//   pc_plus2_fd     PC+2 of instruction_fd
//   valid_fd        instruction_fd is real
//   predicted_fd    next PC already steered by predecode
//   instrMem_stall  fetch is waiting on memory
// -----------------------------------------------------------------------------
module fetch_issue
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_d,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_d,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_stall,
    output logic [15:0] instruction_fd,
    output logic [15:0] pc_plus2_fd,
    output logic        valid_fd,
    output logic        predicted_fd,
    output logic        instrMem_stall
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic         r_drop;
    logic [15:0]  r_instr;
    logic [15:0]  r_pc2;
    logic         r_valid;
    logic         r_pred;
    logic         r_rd;
    logic [15:0]  r_addr;
    logic         r_stall;

    fetch_state_t w_state_nx;
    logic         w_drop_nx;
    logic [15:0]  w_instr_nx;
    logic [15:0]  w_pc2_nx;
    logic         w_valid_nx;
    logic         w_pred_nx;
    logic         w_rd_nx;
    logic [15:0]  w_addr_nx;
    logic         w_stall_nx;
    logic         w_capture;

    logic         w_redirect;
    logic         w_halt;
    logic [15:0]  w_next_pc;
    logic [15:0]  w_pc_plus2;
    logic         w_predicted;
    logic         w_unused_stall;

    // Memory busy is implied by a request without done; the request is simply held.
    assign w_unused_stall = imem_stall;

    // HALTED only leaves through reset, so redirects are ignored there.
    assign w_redirect = redirect && (r_state != HALTED);
    assign w_halt     = halt_d && !hold_d && !redirect;

    fetch_next_pc #(
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .i_rst         (rst),
        .i_redirect    (w_redirect),
        .i_redirect_pc (redirect_pc),
        .i_capture     (w_capture),
        .i_instr       (imem_data),
        .i_pc          (r_pc),
        .o_next_pc     (w_next_pc),
        .o_pc_plus2    (w_pc_plus2),
        .o_predicted   (w_predicted)
    );

    // Fetch controller next-state and next-output logic.
    always_comb begin
        w_state_nx = r_state;
        w_drop_nx  = r_drop;
        w_instr_nx = r_instr;
        w_pc2_nx   = r_pc2;
        w_valid_nx = r_valid;
        w_pred_nx  = r_pred;
        w_rd_nx    = r_rd;
        w_addr_nx  = r_addr;
        w_stall_nx = r_stall;
        w_capture  = 1'b0;

        if (w_redirect) begin
            w_instr_nx = NOP_INSTR;
            w_valid_nx = 1'b0;
            w_pred_nx  = 1'b0;
            w_rd_nx    = 1'b1;
            if (r_rd && !imem_done) begin
                // Outstanding request cannot be withdrawn: wait it out and drop it.
                w_drop_nx  = 1'b1;
                w_state_nx = WAIT;
                w_stall_nx = 1'b1;
            end else begin
                w_drop_nx  = 1'b0;
                w_state_nx = FETCH;
                w_addr_nx  = redirect_pc;
                w_stall_nx = 1'b0;
            end
        end else begin
            case (r_state)
                FETCH, WAIT: begin
                    if (!r_rd) begin
                        // First cycle after reset: nothing of ours is in flight.
                        w_drop_nx  = 1'b0;
                        w_instr_nx = NOP_INSTR;
                        w_valid_nx = 1'b0;
                        w_pred_nx  = 1'b0;
                        w_stall_nx = 1'b0;
                        if (w_halt) begin
                            w_state_nx = HALTED;
                            w_rd_nx    = 1'b0;
                        end else begin
                            w_state_nx = FETCH;
                            w_rd_nx    = 1'b1;
                            w_addr_nx  = r_pc;
                        end
                    end else if (!imem_done) begin
                        w_state_nx = WAIT;
                        w_stall_nx = 1'b1;
                        w_instr_nx = NOP_INSTR;
                        w_valid_nx = 1'b0;
                        w_pred_nx  = 1'b0;
                        w_rd_nx    = 1'b1;
                    end else if (r_drop || w_halt) begin
                        // Completed data belongs to a flushed or post-HALT fetch.
                        w_drop_nx  = 1'b0;
                        w_instr_nx = NOP_INSTR;
                        w_valid_nx = 1'b0;
                        w_pred_nx  = 1'b0;
                        w_stall_nx = 1'b0;
                        if (w_halt) begin
                            w_state_nx = HALTED;
                            w_rd_nx    = 1'b0;
                        end else begin
                            w_state_nx = FETCH;
                            w_rd_nx    = 1'b1;
                            w_addr_nx  = r_pc;
                        end
                    end else begin
                        w_capture  = 1'b1;
                        w_instr_nx = imem_data;
                        w_valid_nx = 1'b1;
                        w_pc2_nx   = w_pc_plus2;
                        w_pred_nx  = w_predicted;
                        w_stall_nx = 1'b0;
                        if (hold_d) begin
                            w_state_nx = HOLD;
                            w_rd_nx    = 1'b0;
                        end else begin
                            w_state_nx = FETCH;
                            w_rd_nx    = 1'b1;
                            w_addr_nx  = w_next_pc;
                        end
                    end
                end
                HOLD: begin
                    w_stall_nx = 1'b0;
                    if (hold_d) begin
                        w_rd_nx = 1'b0;
                    end else begin
                        // Decode takes the frozen instruction on this edge.
                        w_instr_nx = NOP_INSTR;
                        w_valid_nx = 1'b0;
                        w_pred_nx  = 1'b0;
                        if (w_halt) begin
                            w_state_nx = HALTED;
                            w_rd_nx    = 1'b0;
                        end else begin
                            w_state_nx = FETCH;
                            w_rd_nx    = 1'b1;
                            w_addr_nx  = r_pc;
                        end
                    end
                end
                HALTED: begin
                    w_rd_nx    = 1'b0;
                    w_instr_nx = NOP_INSTR;
                    w_valid_nx = 1'b0;
                    w_pred_nx  = 1'b0;
                    w_stall_nx = 1'b0;
                    w_drop_nx  = 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover as if just reset.
                    w_state_nx = FETCH;
                    w_rd_nx    = 1'b0;
                    w_drop_nx  = 1'b1;
                    w_instr_nx = NOP_INSTR;
                    w_valid_nx = 1'b0;
                    w_pred_nx  = 1'b0;
                    w_stall_nx = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; drop starts set so a stale done after reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b1;
            r_instr <= NOP_INSTR;
            r_pc2   <= 16'h0000;
            r_valid <= 1'b0;
            r_pred  <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= RESET_PC;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_next_pc;
            r_drop  <= w_drop_nx;
            r_instr <= w_instr_nx;
            r_pc2   <= w_pc2_nx;
            r_valid <= w_valid_nx;
            r_pred  <= w_pred_nx;
            r_rd    <= w_rd_nx;
            r_addr  <= w_addr_nx;
            r_stall <= w_stall_nx;
        end
    end

    assign imem_rd        = r_rd;
    assign imem_addr      = r_addr;
    assign instruction_fd = r_instr;
    assign pc_plus2_fd    = r_pc2;
    assign valid_fd       = r_valid;
    assign predicted_fd   = r_pred;
    assign instrMem_stall = r_stall;

endmodule
